vc_arbiter: RTL

- Downstream stage of the initial logic: drains the VC0 and VC1 virtual-channel FIFOs and routes each word to one of two destination FIFOs, D0 or D1.
- Arbitration is strict priority, with VC0 above VC1.
- Any pop is blocked while either destination FIFO reports almost_full.
- Routing is taken from bit 4 of the popped word. Bit 5 is the VC class bit, already consumed upstream.

---
 rtl/vc_arbiter.sv | 135 +++++++++++++
 1 files changed

// File: rtl/vc_arbiter.sv
// vc_arbiter: strict-priority drain of the VC0/VC1 FIFOs into destination FIFOs D0/D1.
// Optional starvation guard for VC1 enabled by defining VC_ARB_STARVE_GUARD_EN.
module vc_arbiter #(
   parameter int unsigned data_width    = 6,
   parameter int unsigned dest_bit      = 4,
   parameter int unsigned max_vc0_burst = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  empty_fifo_VC0,
   input  logic                  almost_empty_fifo_VC0,
   input  logic [data_width-1:0] data_out_VC0,
   input  logic                  empty_fifo_VC1,
   input  logic                  almost_empty_fifo_VC1,
   input  logic [data_width-1:0] data_out_VC1,
   input  logic                  almost_full_D0,
   input  logic                  almost_full_D1,
   output logic                  pop_VC0_fifo,
   output logic                  pop_VC1_fifo,
   output logic                  push_D0,
   output logic                  push_D1,
   output logic [data_width-1:0] data_out,
   output logic                  idle
);

   typedef enum logic [1:0] {
      IDLE      = 2'b00,
      GRANT_VC0 = 2'b01,
      GRANT_VC1 = 2'b10,
      STALL     = 2'b11
   } state_t;

   state_t                state_q, state_d;
   logic                  s1_valid_q, s1_valid_d;
   logic                  s1_sel_q, s1_sel_d;
   logic                  push_d0_q, push_d0_d;
   logic                  push_d1_q, push_d1_d;
   logic [data_width-1:0] data_q, data_d;
   logic                  idle_q, idle_d;

   logic                  pop0, pop1;
   logic                  elig0, elig1;
   logic                  dest_full;
   logic                  force_vc1;
   logic [data_width-1:0] s1_data;

`ifdef VC_ARB_STARVE_GUARD_EN
   localparam logic [2:0] BURST_MAX = 3'(max_vc0_burst);
   logic [2:0]            burst_q, burst_d;
`endif

   // Pops are a decode of the registered grant state.
   assign pop0 = (state_q == GRANT_VC0);
   assign pop1 = (state_q == GRANT_VC1);

   always_comb begin
      // A FIFO already being popped while holding its last word must not be popped again.
      elig0     = ~empty_fifo_VC0 & ~(pop0 & almost_empty_fifo_VC0);
      elig1     = ~empty_fifo_VC1 & ~(pop1 & almost_empty_fifo_VC1);
      dest_full = almost_full_D0 | almost_full_D1;
`ifdef VC_ARB_STARVE_GUARD_EN
      force_vc1 = (burst_q >= BURST_MAX);
`else
      force_vc1 = 1'b0;
`endif

      if (dest_full)
         state_d = STALL;
      else if (force_vc1 && elig1)
         state_d = GRANT_VC1;
      else if (elig0)
         state_d = GRANT_VC0;
      else if (elig1)
         state_d = GRANT_VC1;
      else
         state_d = IDLE;

`ifdef VC_ARB_STARVE_GUARD_EN
      burst_d = burst_q;
      case (state_d)
         GRANT_VC0: if (elig1 && burst_q < BURST_MAX) burst_d = burst_q + 3'd1;
         GRANT_VC1: burst_d = '0;
         IDLE:      burst_d = '0;
         default:   burst_d = burst_q;
      endcase
`endif

      // FIFO read data is valid the cycle after the pop, so s1 is the live read port.
      s1_valid_d = pop0 | pop1;
      s1_sel_d   = pop0 ? 1'b0 : (pop1 ? 1'b1 : s1_sel_q);
      s1_data    = s1_sel_q ? data_out_VC1 : data_out_VC0;

      push_d0_d = s1_valid_q & ~s1_data[dest_bit];
      push_d1_d = s1_valid_q &  s1_data[dest_bit];
      data_d    = s1_valid_q ? s1_data : data_q;

      idle_d = empty_fifo_VC0 & empty_fifo_VC1
             & (state_d != GRANT_VC0) & (state_d != GRANT_VC1)
             & ~s1_valid_d & ~push_d0_d & ~push_d1_d;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= IDLE;
         s1_valid_q <= 1'b0;
         s1_sel_q   <= 1'b0;
         push_d0_q  <= 1'b0;
         push_d1_q  <= 1'b0;
         data_q     <= '0;
         idle_q     <= 1'b1;
`ifdef VC_ARB_STARVE_GUARD_EN
         burst_q    <= '0;
`endif
      end else begin
         state_q    <= state_d;
         s1_valid_q <= s1_valid_d;
         s1_sel_q   <= s1_sel_d;
         push_d0_q  <= push_d0_d;
         push_d1_q  <= push_d1_d;
         data_q     <= data_d;
         idle_q     <= idle_d;
`ifdef VC_ARB_STARVE_GUARD_EN
         burst_q    <= burst_d;
`endif
      end
   end

   assign pop_VC0_fifo = pop0;
   assign pop_VC1_fifo = pop1;
   assign push_D0      = push_d0_q;
   assign push_D1      = push_d1_q;
   assign data_out     = data_q;
   assign idle         = idle_q;

endmodule
